// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requester blocks and the round-robin arbiter.
// The master side drives enable and requests; the slave side returns the grant.
interface rr_arbiter4_if;
    logic       io_en;
    logic [3:0] io_req;
    logic [3:0] io_grant;
    logic [1:0] io_idx;
    logic       io_valid;
    logic       io_timeout;

    modport master (
        output io_en,
        output io_req,
        input  io_grant,
        input  io_idx,
        input  io_valid,
        input  io_timeout
    );

    modport slave (
        input  io_en,
        input  io_req,
        output io_grant,
        output io_idx,
        output io_valid,
        output io_timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and encoded index.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD consecutive cycles of ownership.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clock,
    input  logic          reset,
    rr_arbiter4_if.slave  io
);
    // state | meaning
    // IDLE  | no owner, grant/idx/valid all zero
    // BUSY  | idx_q owns the resource, grant_q is its one-hot
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] pick_req;
    logic       take;
    logic [1:0] take_idx;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be within 1..255");
    end

    // Returns {found, index}: first set bit of mask scanning from ptr upward with wrap.
    function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] i;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            i = ptr + 2'(k);
            if (mask[i]) res = {1'b1, i};
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic [2:0] pick_to;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        take     = 1'b0;
        take_idx = 2'd0;
        pick_req = pick(io.io_req, ptr_q);
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        pick_to    = pick(io.io_req & ~grant_q, ptr_q);
`endif
        if (!io.io_en) begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end else if (state_q == IDLE) begin
            take     = pick_req[2];
            take_idx = pick_req[1:0];
        end else if (io.io_req[idx_q]) begin
`ifdef ARB_TIMEOUT_EN
            // Forced revoke only hands over to someone else; a lone owner keeps it.
            if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                timeout_d  = 1'b1;
                hold_cnt_d = '0;
                take       = pick_to[2];
                take_idx   = pick_to[1:0];
            end else begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
`endif
        end else if (pick_req[2]) begin
            take     = 1'b1;
            take_idx = pick_req[1:0];
        end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end

        if (take) begin
            state_d = BUSY;
            grant_d = 4'b0001 << take_idx;
            idx_d   = take_idx;
            ptr_d   = take_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign io.io_timeout = timeout_q;
`else
    assign io.io_timeout = 1'b0;
`endif

    assign io.io_grant = grant_q;
    assign io.io_idx   = idx_q;
    assign io.io_valid = |grant_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4: table of {inputs, expected outputs} per cycle,
// plus a rotating-fairness sequence where each owner releases right after being granted.
module tb_rr_arbiter4;
    logic clock = 1'b0;
    logic reset = 1'b1;

    rr_arbiter4_if arb_if();

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (arb_if.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       tout;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rst, input logic en, input logic [3:0] req,
                                input logic [3:0] grant, input logic [1:0] idx,
                                input logic tout, input int n = 1);
        vec_t v;
        v.rst   = rst;
        v.en    = en;
        v.req   = req;
        v.grant = grant;
        v.idx   = idx;
        v.valid = (grant != 4'b0000);
        v.tout  = tout;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [3:0] req);
        reset         = rst;
        arb_if.io_en  = en;
        arb_if.io_req = req;
        @(negedge clock);
    endtask

    initial begin
        logic [3:0] want;
        arb_if.io_en  = 1'b0;
        arb_if.io_req = 4'b0000;

`ifdef ARB_TIMEOUT_EN
        add(1, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 1, 4'b0011, 4'b0001, 0, 0, 4);
        add(0, 1, 4'b0011, 4'b0010, 1, 1);
        add(0, 1, 4'b0011, 4'b0010, 1, 0, 3);
        add(0, 1, 4'b0011, 4'b0001, 0, 1);
        add(0, 1, 4'b0001, 4'b0001, 0, 0, 3);
        add(0, 1, 4'b0001, 4'b0001, 0, 1);
        add(0, 1, 4'b0001, 4'b0001, 0, 0, 3);
        add(0, 1, 4'b0001, 4'b0001, 0, 1);
        add(0, 0, 4'b0001, 4'b0000, 0, 0);
        add(0, 1, 4'b0001, 4'b0001, 0, 0);
        add(1, 1, 4'b0001, 4'b0000, 0, 0);
`else
        // single requester: grant, long hold, release
        add(1, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 1, 4'b0100, 4'b0100, 2, 0, 6);
        add(0, 1, 4'b0000, 4'b0000, 0, 0);
        // all requesting, each owner releases after two cycles
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add(0, 1, 4'b1111, 4'b0001, 0, 0, 2);
        add(0, 1, 4'b1110, 4'b0010, 1, 0);
        add(0, 1, 4'b1111, 4'b0010, 1, 0, 2);
        add(0, 1, 4'b1101, 4'b0100, 2, 0);
        add(0, 1, 4'b1111, 4'b0100, 2, 0, 2);
        add(0, 1, 4'b1011, 4'b1000, 3, 0);
        add(0, 1, 4'b1111, 4'b1000, 3, 0, 2);
        add(0, 1, 4'b0111, 4'b0001, 0, 0);
        // wrap-around from owner 3
        add(0, 1, 4'b1000, 4'b1000, 3, 0);
        add(0, 1, 4'b0011, 4'b0001, 0, 0);
        add(0, 1, 4'b0010, 4'b0010, 1, 0);
        // enable drop with owner 1, then regrant
        add(0, 0, 4'b0010, 4'b0000, 0, 0);
        add(0, 1, 4'b0010, 4'b0010, 1, 0);
        // reset mid-grant, enable low blocks grants
        add(0, 1, 4'b1101, 4'b0100, 2, 0);
        add(0, 1, 4'b1111, 4'b0100, 2, 0);
        add(1, 1, 4'b1111, 4'b0000, 0, 0);
        add(0, 0, 4'b1111, 4'b0000, 0, 0);
        add(0, 1, 4'b1111, 4'b0001, 0, 0);
        // a request withdrawn before service is forgotten
        add(0, 1, 4'b0011, 4'b0001, 0, 0);
        add(0, 1, 4'b0001, 4'b0001, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 0, 0, 2);
`endif

        @(negedge clock);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].req);
            chk($sformatf("vec%0d grant", i), arb_if.io_grant, vecs[i].grant);
            chk($sformatf("vec%0d idx", i), {2'b00, arb_if.io_idx}, {2'b00, vecs[i].idx});
            chk($sformatf("vec%0d valid", i), {3'b000, arb_if.io_valid}, {3'b000, vecs[i].valid});
            chk($sformatf("vec%0d timeout", i), {3'b000, arb_if.io_timeout}, {3'b000, vecs[i].tout});
            chk($sformatf("vec%0d onehot", i), {3'b000, $onehot0(arb_if.io_grant)}, 4'b0001);
        end

        // every owner releases immediately: strict rotation 0,1,2,3,0 with no idle gap
        step(1, 0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, ~arb_if.io_grant);
            want = 4'b0001 << (k % 4);
            chk($sformatf("rotate%0d grant", k), arb_if.io_grant, want);
            chk($sformatf("rotate%0d valid", k), {3'b000, arb_if.io_valid}, 4'b0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
